sram_arbiter: RTL
=================

# sram_arbiter

Time-shares the single 8-bit asynchronous external SRAM (21-bit byte address) between the CPU word port and the video fetch port. It sits between `system_2MB`'s memory requesters and the `SRAM_A`/`SRAM_D`/`SRAM_WE_n` pins. It splits 16-bit CPU accesses into two byte cycles, serves video as fixed-length read bursts, and generates SRAM strobes with programmable wait states.

## Interface
Parameters:
- `AW`, 21, SRAM byte-address width.
- `WAIT`, 1, strobe cycles per byte access (≥1); one byte access = phase of P = WAIT+2 cycles.
- `VID_BURST`, 8, bytes per video burst (≥1).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  level request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  byte address of low byte.
- `cpu_wdata`  in  16  write data, low byte at `cpu_addr`.
- `cpu_be`  in  2  write byte enables [0]=low, [1]=high; ignored on reads.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  16  read data, valid with `cpu_ack`.
- `vid_req`  in  1  burst request.
- `vid_addr`  in  AW  burst start byte address.
- `vid_data`  out  8  fetched byte.
- `vid_valid`  out  1  one-cycle pulse per byte.
- `vid_done`  out  1  pulse with the last byte of a burst.
- `sram_a`  out  AW  SRAM address.
- `sram_dout`  out  8  write data to pad.
- `sram_oe`  out  1  pad drive enable (1 = drive `sram_dout`).
- `sram_we_n`  out  1  SRAM write strobe, active low.
- `sram_din`  in  8  data from pad.

## Operation
- States: IDLE, VID, CPU_LO, CPU_HI, CPU_ACK, VID_GAP.
- Phase (one byte access, P cycles, counter 0..P-1):
  - cycle 0: setup.
  - cycles 1..WAIT: strobe; `sram_we_n`=0 if write.
  - cycle P-1: hold/sample; `sram_we_n`=1.
  - `sram_a`, and `sram_dout`/`sram_oe` for writes, are stable for the whole phase. `sram_oe`=0 for reads. Read data is captured from `sram_din` at the end of cycle P-1.
- IDLE grant priority, evaluated each cycle:
  - `cpu_req` && `last_vid` → CPU.
  - else `vid_req` → VID.
  - else `cpu_req` → CPU.
  - At grant, the address, data, `cpu_be` and `cpu_we` are latched. `last_vid` is set when a burst completes and cleared when the CPU is granted.
- CPU path:
  - CPU_LO accesses `addr`; CPU_HI accesses `addr+1` (mod 2^AW), then CPU_ACK.
  - On a write, a phase whose byte-enable bit is 0 is skipped entirely (no strobe). A write with `cpu_be`=00 goes IDLE→CPU_ACK directly.
  - CPU_ACK lasts 1 cycle: `cpu_ack`=1, `cpu_rdata` = {hi, lo} for reads (unchanged on writes). It then returns to IDLE.
- VID path:
  - VID_BURST consecutive phases at addr, addr+1, … (wrap mod 2^AW).
  - After each phase, `vid_valid` and `vid_data` are registered high/valid for the following cycle.
  - After the last phase the state enters VID_GAP (1 cycle, `vid_valid`=`vid_done`=1), then IDLE.
- Requests are ignored in CPU_ACK and VID_GAP; requesters drop `cpu_req` / `vid_req` there.
- No preemption: a burst or a CPU word always completes.

## Timing
- Reset values: `sram_we_n`=1, `sram_oe`=0, `sram_a`=0, `sram_dout`=0, `cpu_ack`=0, `cpu_rdata`=0, `vid_data`=0, `vid_valid`=0, `vid_done`=0; state IDLE; `last_vid`=0.
- Reset mid-access: `sram_we_n` goes to 1 asynchronously. The aborted access produces no ack/valid.
- All outputs are registered.
- CPU word latency:
  - request seen in IDLE at edge k → first phase starts at cycle k+1.
  - full word (2 phases): `cpu_ack` at cycle k+1+2P.
  - one enabled byte: k+1+P.
  - be=00: k+1.
- Video: byte n (0-based) has `vid_valid` at cycle k+1+(n+1)P. Throughput is 1 byte per P cycles.
- Simultaneous `cpu_req` and `vid_req` in IDLE with `last_vid`=0 → VID wins. Afterwards the CPU is guaranteed the next grant.
- The CPU wait bound is one burst plus gap: VID_BURST·P+1 cycles before its own grant.

## Test plan
- WAIT=1 (P=3): CPU write 0xBEEF at 0x000100, be=11 → `sram_we_n` low for 1 cycle at address 0x000100 with data 0xEF, then at 0x000101 with 0xBE; `cpu_ack` 7 cycles after the request was seen.
- CPU read at 0x1FFFFF with SRAM model holding 0x12 at 0x1FFFFF and 0x34 at 0x000000 → `cpu_rdata`=0x3412 (address wrap).
- Write be=10 at 0x000200 → only 0x000201 strobed; ack after 4 cycles. Write be=00 → no strobe; ack after 1 cycle.
- VID_BURST=8 at 0x000400 over SRAM pattern byte=addr[7:0] → `vid_data` sequence 0x00..0x07 at 3-cycle spacing; `vid_done` with 0x07; `sram_oe`=0 and `sram_we_n`=1 throughout.
- `cpu_req` and `vid_req` asserted together and held → burst first, then CPU word, then the next burst. The CPU is never starved.
- Assert `reset` during a write strobe → `sram_we_n`=1 immediately, no `cpu_ack`. After release the arbiter is in IDLE and a new read completes normally.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - CPU word port, video burst port and SRAM pad signals
interface sram_arbiter_if #(
  parameter int AW = 21
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic [1:0]    cpu_be;
  logic          cpu_ack;
  logic [15:0]   cpu_rdata;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_data;
  logic          vid_valid;
  logic          vid_done;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_dout;
  logic          sram_oe;
  logic          sram_we_n;
  logic [7:0]    sram_din;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, vid_req, vid_addr, sram_din,
    output cpu_ack, cpu_rdata, vid_data, vid_valid, vid_done,
    output sram_a, sram_dout, sram_oe, sram_we_n
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, vid_req, vid_addr, sram_din,
    input  cpu_ack, cpu_rdata, vid_data, vid_valid, vid_done,
    input  sram_a, sram_dout, sram_oe, sram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one 8-bit async SRAM between a CPU word port and video read bursts
module sram_arbiter #(
  parameter int AW        = 21,
  parameter int WAIT      = 1,
  parameter int VID_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);
  localparam int P  = WAIT + 2;
  localparam int CW = $clog2(P);
  localparam int BW = (VID_BURST > 1) ? $clog2(VID_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(P - 1);
  localparam logic [CW-1:0] CNT_WAIT   = CW'(WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(VID_BURST - 1);

  typedef enum logic [2:0] {IDLE, VID, CPU_LO, CPU_HI, CPU_ACK, VID_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [7:0]    lo_q, lo_d;
  logic          last_vid_q, last_vid_d;
  logic [7:0]    sram_dout_q, sram_dout_d;
  logic          sram_oe_q, sram_oe_d;
  logic          sram_we_n_q, sram_we_n_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [15:0]   cpu_rdata_q, cpu_rdata_d;
  logic [7:0]    vid_data_q, vid_data_d;
  logic          vid_valid_q, vid_valid_d;
  logic          vid_done_q, vid_done_d;

  logic phase_end;
  logic grant_cpu;

  assign phase_end = (cnt_q == CNT_LAST);
  // CPU wins a tie only right after a burst, which bounds its wait to one burst
  assign grant_cpu = bus.cpu_req && (last_vid_q || !bus.vid_req);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    lo_d        = lo_q;
    last_vid_d  = last_vid_q;
    sram_dout_d = sram_dout_q;
    sram_oe_d   = sram_oe_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    cpu_ack_d   = 1'b0;
    vid_valid_d = 1'b0;
    vid_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          last_vid_d = 1'b0;
          we_d       = bus.cpu_we;
          be_d       = bus.cpu_we ? bus.cpu_be : 2'b11;
          wdata_d    = bus.cpu_wdata;
          cnt_d      = '0;
          if (be_d[0]) begin
            state_d     = CPU_LO;
            addr_d      = bus.cpu_addr;
            sram_dout_d = bus.cpu_wdata[7:0];
            sram_oe_d   = bus.cpu_we;
          end else if (be_d[1]) begin
            state_d     = CPU_HI;
            addr_d      = bus.cpu_addr + AW'(1);
            sram_dout_d = bus.cpu_wdata[15:8];
            sram_oe_d   = bus.cpu_we;
          end else begin
            state_d   = CPU_ACK;
            cpu_ack_d = 1'b1;
          end
        end else if (bus.vid_req) begin
          state_d   = VID;
          addr_d    = bus.vid_addr;
          cnt_d     = '0;
          burst_d   = '0;
          sram_oe_d = 1'b0;
          we_d      = 1'b0;
        end
      end
      VID: begin
        if (phase_end) begin
          vid_data_d  = bus.sram_din;
          vid_valid_d = 1'b1;
          if (burst_q == BURST_LAST) begin
            state_d    = VID_GAP;
            vid_done_d = 1'b1;
            last_vid_d = 1'b1;
          end else begin
            addr_d  = addr_q + AW'(1);
            burst_d = burst_q + BW'(1);
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CPU_LO: begin
        if (phase_end) begin
          lo_d = bus.sram_din;
          if (be_q[1]) begin
            state_d     = CPU_HI;
            addr_d      = addr_q + AW'(1);
            sram_dout_d = wdata_q[15:8];
            cnt_d       = '0;
          end else begin
            state_d   = CPU_ACK;
            cpu_ack_d = 1'b1;
            sram_oe_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CPU_HI: begin
        if (phase_end) begin
          state_d   = CPU_ACK;
          cpu_ack_d = 1'b1;
          sram_oe_d = 1'b0;
          if (!we_q) cpu_rdata_d = {bus.sram_din, lo_q};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CPU_ACK: state_d = IDLE;
      VID_GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // strobe from the next phase position so the pin is a clean flop output
    sram_we_n_d = !(we_d && (state_d == CPU_LO || state_d == CPU_HI) &&
                    (cnt_d != '0) && (cnt_d <= CNT_WAIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      burst_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      lo_q        <= '0;
      last_vid_q  <= 1'b0;
      sram_dout_q <= '0;
      sram_oe_q   <= 1'b0;
      sram_we_n_q <= 1'b1;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      vid_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      lo_q        <= lo_d;
      last_vid_q  <= last_vid_d;
      sram_dout_q <= sram_dout_d;
      sram_oe_q   <= sram_oe_d;
      sram_we_n_q <= sram_we_n_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      vid_done_q  <= vid_done_d;
    end
  end

  assign bus.sram_a    = addr_q;
  assign bus.sram_dout = sram_dout_q;
  assign bus.sram_oe   = sram_oe_q;
  assign bus.sram_we_n = sram_we_n_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_done  = vid_done_q;
endmodule
